uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Downstream consumer of the 2 Mbps UART receiver byte strobe. Hunts for a sync byte, assembles `SYNC OP ADDR LEN PAYLOAD[LEN] CSUM` frames, buffers the payload, verifies the checksum, then streams each payload byte out with a valid/ready handshake and an incrementing address. Malformed, stalled or overrun frames are dropped and reported on error pulses.

## Interface
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `MAX_LEN`, 16: largest accepted payload length.
- `TIMEOUT_CYC`, 2500: idle cycles allowed between bytes inside a frame. This is 10 byte-times at 25 clk/bit.
- `LW`, $clog2(MAX_LEN+1): payload index/length width.
- Clock and reset: one clock, `sys_clk`; reset `sys_rst` is synchronous and active-high.
- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst`  in  1  synchronous active-high reset.
- `uart_rec`  in  1  byte-complete flag from the receiver; its rising edge marks a new byte.
- `uart_data_in`  in  8  received byte; valid in the cycle `uart_rec` is first seen high.
- `out_valid`  out  1  payload beat valid.
- `out_ready`  in  1  sink accepts beat.
- `out_op`  out  8  frame OP byte; stable for the whole frame delivery.
- `out_addr`  out  8  ADDR + beat index, mod 256.
- `out_data`  out  8  payload byte.
- `out_last`  out  1  final beat of frame.
- `frame_ok`  out  1  1-cycle pulse when a frame passes its checksum.
- `err_csum`, `err_len`, `err_timeout`, `err_overrun`  out  1 each  1-cycle error pulses.
- `frame_cnt`  out  16  count of good frames; wraps at 65535.

## Operation
- Byte strobe `stb = uart_rec & ~rec_d`, where `rec_d` is `uart_rec` registered. `stb` is consumed in the same cycle.
- States:
  - IDLE: `stb` with data == SYNC_BYTE → OP. Any other byte is ignored silently.
  - OP: `stb` → latch op, sum = data → ADDR.
  - ADDR: `stb` → latch addr, add data to sum → LEN.
  - LEN: `stb` → add data to sum.
    - data > MAX_LEN → `err_len`, IDLE.
    - data == 0 → CSUM.
    - otherwise → PAYLOAD, idx = 0.
  - PAYLOAD: `stb` → buf[idx] = data, add data to sum, idx++. → CSUM after LEN bytes.
  - CSUM: `stb` compares data with the 8-bit sum.
    - Mismatch → `err_csum`, IDLE.
    - Match, LEN > 0 → `frame_ok`, `frame_cnt`++, DELIVER with idx = 0.
    - Match, LEN == 0 → `frame_ok`, `frame_cnt`++, IDLE; no beats.
  - DELIVER: `out_valid` = 1; `out_data` = buf[idx]; `out_last` = (idx == LEN-1).
    - On `out_valid & out_ready` → idx++.
    - After the last beat transfers → IDLE.
- Sum is 8-bit, mod 256, over OP, ADDR, LEN and payload.
- `out_addr` = addr + idx, truncated to 8 bits, so it wraps FF→00.
- Timeout counter:
  - Cleared on every `stb` and in IDLE/DELIVER.
  - Counts in OP..CSUM.
  - Reaching TIMEOUT_CYC → `err_timeout`, IDLE.
- `stb` during DELIVER: byte dropped, `err_overrun` pulse, delivery continues. A SYNC byte here is not re-hunted.

## Timing
- Reset values:
  - State IDLE.
  - `out_valid`, `out_last`, `frame_ok` and all `err_*` = 0.
  - `out_op`, `out_addr`, `out_data` = 0.
  - `frame_cnt` = 0; `rec_d` = 1, so no false edge when `uart_rec` is high at reset release.
- CSUM `stb` in cycle N → `frame_ok` and `out_valid` high in cycle N+1. `out_valid` holds until accepted.
- One beat per cycle max; `out_ready` held high drains LEN beats in LEN cycles.
- Signals in DELIVER are combinational from `idx` and the buffer. `out_*` stay stable while `out_valid & ~out_ready`.
- Back-to-back frames: the next SYNC is accepted from the first IDLE cycle after the last beat.
- `stb` and timeout in the same cycle → `stb` wins; the counter clears and no error is raised.
- Reset mid-frame or mid-delivery:
  - Returns to IDLE next edge; no pulses are emitted.
  - Buffer contents are don't-care.

## Structure
- Shared package `uart_pkg`:
  - State enum: IDLE, OP, ADDR, LEN, PAYLOAD, CSUM, DELIVER.
  - SYNC_BYTE default.
  - BPS_CNT = 25 and derived TIMEOUT_CYC.
- Sub-module `uart_frame_buf`: MAX_LEN×8 register file with one synchronous write port and one asynchronous read port.

## Test plan
- Good frame: A5 01 10 03 11 22 33 7A, `out_ready` = 1 → `frame_ok`; beats (01,10,11), (01,11,22), (01,12,33) with `out_last` on the third; `frame_cnt` = 1.
- Same frame with CSUM 7B → `err_csum`, no `out_valid`, `frame_cnt` unchanged.
- LEN byte 0x11 with MAX_LEN 16 → `err_len` on that strobe. A following A5 frame parses normally.
- A5 01, then silence → `err_timeout` exactly TIMEOUT_CYC cycles after the 01 strobe; state IDLE.
- Good frame with addr FF, len 2, `out_ready` low for 10 cycles:
  - `out_*` stay stable while stalled.
  - Beat addresses are FF then 00.
  - A byte strobed during the stall → `err_overrun`; the beats are still delivered intact.
- A5 05 00 00 05 (LEN = 0) → `frame_ok`, no beats. Reset asserted mid-payload → IDLE, no pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART frame parser.
// Timeout is ten byte-times of ten bits at BPS_CNT clocks per bit.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         MAX_LEN     = 16;
    localparam int         BPS_CNT     = 25;
    localparam int         TIMEOUT_CYC = BPS_CNT * 10 * 10;
    localparam int         LW          = $clog2(MAX_LEN + 1);
    localparam int         BUF_AW      = $clog2(MAX_LEN);
    localparam int         TW          = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OP      = 3'd1,
        ADDR    = 3'd2,
        LEN     = 3'd3,
        PAYLOAD = 3'd4,
        CSUM    = 3'd5,
        DELIVER = 3'd6
    } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 register file, synchronous write, asynchronous read.
// Contents are not reset; a frame always writes before it reads.
module uart_frame_buf
    import uart_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [BUF_AW-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [BUF_AW-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [MAX_LEN];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Hunts SYNC, assembles SYNC OP ADDR LEN PAYLOAD CSUM frames, checks the sum
// and streams the buffered payload out; bad, stalled or overrun bytes raise error pulses.
module uart_frame_parser
    import uart_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rec,
    input  logic [7:0]  uart_data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_op,
    output logic [7:0]  out_addr,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        frame_ok,
    output logic        err_csum,
    output logic        err_len,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic [15:0] frame_cnt,
    output state_t      dbg_state
);

    // Counter value in the cycle before the pulse, so err_timeout lands
    // exactly TIMEOUT_CYC cycles after the last strobe.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 2);

    state_t          r_state, w_next;
    logic            r_rec_d;
    logic [7:0]      r_op, r_addr, r_sum;
    logic [LW-1:0]   r_len, r_idx;
    logic [TW-1:0]   r_tmo;
    logic [15:0]     r_frame_cnt;
    logic            r_frame_ok, r_err_csum, r_err_len, r_err_tmo, r_err_ovr;

    logic            w_stb, w_in_frame, w_xfer, w_last;
    logic            w_ok, w_err_csum, w_err_len, w_err_tmo, w_err_ovr;
    logic [7:0]      w_rdata;

    assign w_stb      = uart_rec & ~r_rec_d;
    assign w_in_frame = r_state inside {OP, ADDR, LEN, PAYLOAD, CSUM};
    assign w_last     = (r_idx == r_len - LW'(1));

    // Beat handshake: a beat moves on a cycle where out_valid and out_ready
    // are both high; while out_valid & ~out_ready every out_* field holds.
    assign out_valid = (r_state == DELIVER);
    assign w_xfer    = out_valid & out_ready;
    assign out_last  = out_valid & w_last;
    assign out_data  = out_valid ? w_rdata : 8'h00;
    assign out_op    = r_op;
    assign out_addr  = r_addr + 8'(r_idx);

    assign frame_ok    = r_frame_ok;
    assign err_csum    = r_err_csum;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_tmo;
    assign err_overrun = r_err_ovr;
    assign frame_cnt   = r_frame_cnt;
    assign dbg_state   = r_state;

    uart_frame_buf u_buf (
        .i_clk   (sys_clk),
        .i_we    (w_stb && r_state == PAYLOAD),
        .i_waddr (r_idx[BUF_AW-1:0]),
        .i_wdata (uart_data_in),
        .i_raddr (r_idx[BUF_AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_ok       = 1'b0;
        w_err_csum = 1'b0;
        w_err_len  = 1'b0;
        w_err_tmo  = 1'b0;
        w_err_ovr  = 1'b0;
        case (r_state)
            IDLE:    if (w_stb && uart_data_in == SYNC_BYTE) w_next = OP;
            OP:      if (w_stb) w_next = ADDR;
            ADDR:    if (w_stb) w_next = LEN;
            LEN: begin
                if (w_stb) begin
                    if (uart_data_in > 8'(MAX_LEN)) begin
                        w_err_len = 1'b1;
                        w_next    = IDLE;
                    end else if (uart_data_in == 8'h00) begin
                        w_next = CSUM;
                    end else begin
                        w_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: if (w_stb && w_last) w_next = CSUM;
            CSUM: begin
                if (w_stb) begin
                    if (uart_data_in != r_sum) begin
                        w_err_csum = 1'b1;
                        w_next     = IDLE;
                    end else begin
                        w_ok   = 1'b1;
                        w_next = (r_len == '0) ? IDLE : DELIVER;
                    end
                end
            end
            DELIVER: begin
                w_err_ovr = w_stb;
                if (w_xfer && w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_in_frame && !w_stb && r_tmo == TMO_LAST) begin
            w_next    = IDLE;
            w_err_tmo = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rec_d     <= 1'b1;
            r_op        <= '0;
            r_addr      <= '0;
            r_sum       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_frame_cnt <= '0;
            r_frame_ok  <= 1'b0;
            r_err_csum  <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_tmo   <= 1'b0;
            r_err_ovr   <= 1'b0;
        end else begin
            r_rec_d    <= uart_rec;
            r_frame_ok <= w_ok;
            r_err_csum <= w_err_csum;
            r_err_len  <= w_err_len;
            r_err_tmo  <= w_err_tmo;
            r_err_ovr  <= w_err_ovr;
            if (w_ok) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_stb || !w_in_frame) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (w_stb) begin
                case (r_state)
                    OP: begin
                        r_op  <= uart_data_in;
                        r_sum <= uart_data_in;
                    end
                    ADDR: begin
                        r_addr <= uart_data_in;
                        r_sum  <= r_sum + uart_data_in;
                    end
                    LEN: begin
                        r_len <= uart_data_in[LW-1:0];
                        r_sum <= r_sum + uart_data_in;
                        r_idx <= '0;
                    end
                    PAYLOAD: begin
                        r_sum <= r_sum + uart_data_in;
                        r_idx <= r_idx + LW'(1);
                    end
                    CSUM:    r_idx <= '0;
                    default: ;
                endcase
            end
            if (w_xfer) r_idx <= r_idx + LW'(1);
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomised frame stimulus against a byte-level reference model; a monitor
// pops expected beats and pulse events from queues as the DUT produces them.
module tb_uart_frame_parser;
    import uart_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        uart_rec = 1'b0;
    logic [7:0]  uart_data_in = 8'h00;
    logic        out_ready = 1'b0;
    logic        out_valid, out_last, frame_ok;
    logic        err_csum, err_len, err_timeout, err_overrun;
    logic [7:0]  out_op, out_addr, out_data;
    logic [15:0] frame_cnt;
    state_t      dbg_state;

    uart_frame_parser dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .uart_rec     (uart_rec),
        .uart_data_in (uart_data_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_last     (out_last),
        .frame_ok     (frame_ok),
        .err_csum     (err_csum),
        .err_len      (err_len),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun),
        .frame_cnt    (frame_cnt),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #10 sys_clk = ~sys_clk;
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    localparam logic [2:0] EV_OK = 3'd1, EV_CSUM = 3'd2, EV_LEN = 3'd3,
                           EV_TMO = 3'd4, EV_OVR = 3'd5;

    logic [24:0] exp_q[$];
    logic [2:0]  exp_evt_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          model_cnt = 0;
    bit          rdy_random = 1'b0;
    int          tmo_cyc = -1;
    state_t      tmo_state = IDLE;
    logic [24:0] prev_beat = '0;
    logic [24:0] cur_beat;
    bit          prev_stall = 1'b0;
    logic [7:0]  pl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_evt(input logic [2:0] code);
        if (exp_evt_q.size() == 0) check("evt_unexpected", 32'(code), 32'd0);
        else check("event", 32'(code), 32'(exp_evt_q.pop_front()));
    endtask

    // monitor / scoreboard
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            prev_stall = 1'b0;
        end else begin
            cur_beat = {out_op, out_addr, out_data, out_last};
            if (out_valid) begin
                if (prev_stall) check("stall_stable", 32'(cur_beat), 32'(prev_beat));
                if (out_ready) begin
                    if (exp_q.size() == 0) check("beat_unexpected", 32'(cur_beat), 32'd0);
                    else check("beat", 32'(cur_beat), 32'(exp_q.pop_front()));
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_beat  = cur_beat;
                end
            end else begin
                prev_stall = 1'b0;
            end
            if (frame_ok)    chk_evt(EV_OK);
            if (err_csum)    chk_evt(EV_CSUM);
            if (err_len)     chk_evt(EV_LEN);
            if (err_overrun) chk_evt(EV_OVR);
            if (err_timeout) begin
                chk_evt(EV_TMO);
                tmo_cyc   = cyc;
                tmo_state = dbg_state;
            end
        end
    end

    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (rdy_random) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap, output int scyc);
        @(posedge sys_clk);
        #1;
        uart_rec     = 1'b1;
        uart_data_in = b;
        scyc         = cyc;
        repeat (hold) @(posedge sys_clk);
        #1;
        uart_rec     = 1'b0;
        uart_data_in = 8'($urandom);
        repeat (gap) @(posedge sys_clk);
    endtask

    task automatic send_rand(input logic [7:0] b);
        int s;
        send_byte(b, $urandom_range(1, 3), $urandom_range(0, 5), s);
    endtask

    // Reference model: frame outcome from the byte list; csum_xor != 0 corrupts the sum.
    task automatic issue_frame(input logic [7:0] op, input logic [7:0] addr, input int len,
                               input logic [7:0] csum_xor);
        logic [7:0] sum;
        sum = op + addr + 8'(len);
        for (int i = 0; i < len; i++) sum = sum + pl[i];
        if (csum_xor != 8'h00) begin
            exp_evt_q.push_back(EV_CSUM);
        end else begin
            exp_evt_q.push_back(EV_OK);
            model_cnt++;
            for (int i = 0; i < len; i++)
                exp_q.push_back({op, 8'(addr + 8'(i)), pl[i], (i == len - 1)});
        end
        send_rand(SYNC_BYTE);
        send_rand(op);
        send_rand(addr);
        send_rand(8'(len));
        for (int i = 0; i < len; i++) send_rand(pl[i]);
        send_rand(sum ^ csum_xor);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_evt_q.size() != 0) && n < 3000) begin
            @(posedge sys_clk);
            n++;
        end
        check("drain_timeout", 32'(n >= 3000), 32'd0);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    initial begin
        int s, n, kind, len;
        logic [7:0] b;

        // reset with uart_rec high: release must not look like an edge
        uart_rec     = 1'b1;
        uart_data_in = SYNC_BYTE;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_op", 32'(out_op), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_pulses", 32'({frame_ok, err_csum, err_len, err_timeout, err_overrun}), 32'd0);
        repeat (3) @(negedge sys_clk);
        check("rst_no_false_edge", 32'(dbg_state), 32'(IDLE));
        @(posedge sys_clk);
        #1 uart_rec = 1'b0;
        out_ready = 1'b1;

        // good frame A5 01 10 03 11 22 33 7A
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        issue_frame(8'h01, 8'h10, 3, 8'h00);
        drain();
        check("cnt_good", 32'(frame_cnt), 32'(model_cnt));

        // same frame with checksum 7B
        issue_frame(8'h01, 8'h10, 3, 8'h01);
        drain();
        check("cnt_bad_csum", 32'(frame_cnt), 32'(model_cnt));

        // LEN 0x11 rejected, then a normal frame
        exp_evt_q.push_back(EV_LEN);
        send_rand(SYNC_BYTE); send_rand(8'h01); send_rand(8'h10); send_rand(8'h11);
        drain();
        issue_frame(8'h02, 8'h20, 3, 8'h00);
        drain();
        check("cnt_after_len", 32'(frame_cnt), 32'(model_cnt));

        // A5 01 then silence
        tmo_cyc = -1;
        exp_evt_q.push_back(EV_TMO);
        send_rand(SYNC_BYTE);
        send_byte(8'h01, 1, 0, s);
        n = 0;
        while (tmo_cyc < 0 && n < TIMEOUT_CYC + 100) begin
            @(posedge sys_clk);
            n++;
        end
        check("tmo_latency", 32'(tmo_cyc - s), 32'(TIMEOUT_CYC));
        check("tmo_state", 32'(tmo_state), 32'(IDLE));
        drain();

        // stalled delivery at addr FF with an overrun byte (a SYNC) mid-stall
        out_ready = 1'b0;
        pl[0] = 8'hAB; pl[1] = 8'hCD;
        issue_frame(8'h07, 8'hFF, 2, 8'h00);
        @(negedge sys_clk);
        check("stall_valid", 32'(out_valid), 32'd1);
        exp_evt_q.push_back(EV_OVR);
        send_byte(SYNC_BYTE, 1, 0, s);
        repeat (8) @(posedge sys_clk);
        #1 out_ready = 1'b1;
        drain();
        check("cnt_stall", 32'(frame_cnt), 32'(model_cnt));

        // LEN 0: A5 05 00 00 05
        issue_frame(8'h05, 8'h00, 0, 8'h00);
        drain();
        check("cnt_len0", 32'(frame_cnt), 32'(model_cnt));

        // reset mid-payload
        send_rand(SYNC_BYTE); send_rand(8'h01); send_rand(8'h10); send_rand(8'h03); send_rand(8'h11);
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        model_cnt = 0;
        @(negedge sys_clk);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        check("midrst_cnt", 32'(frame_cnt), 32'd0);
        repeat (20) @(posedge sys_clk);
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        issue_frame(8'h01, 8'h10, 3, 8'h00);
        drain();
        check("cnt_after_rst", 32'(frame_cnt), 32'(model_cnt));

        // randomised frames with random backpressure
        rdy_random = 1'b1;
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                if (b == SYNC_BYTE) b = 8'h00;
                send_rand(b);
            end
            kind = $urandom_range(0, 99);
            if (kind < 15) begin
                exp_evt_q.push_back(EV_LEN);
                send_rand(SYNC_BYTE);
                send_rand(8'($urandom));
                send_rand(8'($urandom));
                send_rand(8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                len = $urandom_range(0, MAX_LEN);
                for (int j = 0; j < 16; j++) pl[j] = 8'($urandom);
                issue_frame(8'($urandom), 8'($urandom), len,
                            (kind < 30) ? 8'($urandom_range(1, 255)) : 8'h00);
            end
            drain();
            check("cnt_rand", 32'(frame_cnt), 32'(model_cnt));
        end
        rdy_random = 1'b0;
        @(posedge sys_clk);
        #1 out_ready = 1'b1;
        drain();
        check("beat_q_empty", 32'(exp_q.size()), 32'd0);
        check("evt_q_empty", 32'(exp_evt_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
